// File: rtl/ysyx_22040237_ifu.sv
// Instruction fetch unit: issues one fetch at a time to instruction memory,
// holds the returned word for decode, and computes the next pc on handoff.
//
// Optional feature: define YSYX_22040237_IFU_MISALIGN_CHK_EN to trap
// misaligned next-pc values into a sticky ERR state (fetch_misalign=1).
// Without the macro the next pc is issued as-is and fetch_misalign is 0.
//
// Handshakes (valid/ready):
//   imem request : a request transfers on a rising edge where
//                  imem_req_valid && imem_req_ready; addr is held stable
//                  while valid is high and ready is low.
//   imem response: imem_rsp_valid is a one-cycle strobe, only observed in
//                  WAIT (one outstanding request, so no ready is needed).
//   decode       : pc/inst transfer on a rising edge where
//                  inst_valid && id_ready; jump_flag/jump_pc are sampled
//                  only on that edge.
module ysyx_22040237_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic        inst_valid,
  input  logic        id_ready,
  input  logic        jump_flag,
  input  logic [31:0] jump_pc,
  output logic        fetch_misalign,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc_nxt;
  logic        handoff;
  logic        bad_target;

  // Next sequential or redirected pc; pc + 4 wraps naturally at 2^32.
  assign pc_nxt  = jump_flag ? jump_pc : (pc + 32'd4);
  assign handoff = (state == S_HOLD) && id_ready;

`ifdef YSYX_22040237_IFU_MISALIGN_CHK_EN
  assign bad_target     = (pc_nxt[1:0] != 2'b00);
  assign fetch_misalign = (state == S_ERR);
`else
  assign bad_target     = 1'b0;
  assign fetch_misalign = 1'b0;
`endif

  assign imem_req_valid = (state == S_REQ);
  assign imem_req_addr  = pc;
  assign inst_valid     = (state == S_HOLD);
  assign state_dbg      = state;

  // State register; reset abandons any in-flight request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; responses are only observed while waiting for one.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: state_nxt = S_REQ;
      S_REQ:  if (imem_req_ready) state_nxt = S_WAIT;
      S_WAIT: if (imem_rsp_valid) state_nxt = S_HOLD;
      S_HOLD: if (id_ready) state_nxt = bad_target ? S_ERR : S_REQ;
      S_ERR:  state_nxt = S_ERR;
      default: state_nxt = S_IDLE;
    endcase
  end

  // pc only moves on handoff; a misaligned target is still loaded for visibility.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (handoff) begin
      pc <= pc_nxt;
    end
  end

  // Instruction latch; stray responses outside WAIT never reach inst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst <= 32'h0;
    end else if ((state == S_WAIT) && imem_rsp_valid) begin
      inst <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_ysyx_22040237_ifu.sv
// Directed bench for ysyx_22040237_ifu. Build with
// +define+YSYX_22040237_IFU_MISALIGN_CHK_EN to exercise the trap variant.
module tb_ysyx_22040237_ifu;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        inst_valid;
  logic        id_ready;
  logic        jump_flag;
  logic [31:0] jump_pc;
  logic        fetch_misalign;
  logic [2:0]  state_dbg;

  int          n_checks;
  int          n_errors;
  logic [31:0] exp_q[$];
  logic [31:0] prev_inst;

  ysyx_22040237_ifu #(.RESET_PC(32'h8000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .pc             (pc),
    .inst           (inst),
    .inst_valid     (inst_valid),
    .id_ready       (id_ready),
    .jump_flag      (jump_flag),
    .jump_pc        (jump_pc),
    .fetch_misalign (fetch_misalign),
    .state_dbg      (state_dbg)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete fetch starting in REQ. Noise is driven on rsp/jump inputs
  // outside the cycles where they are meaningful; it must have no effect.
  task automatic fetch(input logic [31:0] data, input logic jf, input logic [31:0] jpc,
                       input int req_stall, input int hold_stall);
    logic [31:0] a;
    a = exp_q.pop_front();
    id_ready       = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hBAD0_BAD0;
    jump_flag      = 1'b1;
    jump_pc        = 32'hDEAD_BEE0;
    imem_req_ready = 1'b0;
    for (int i = 0; i < req_stall; i++) begin
      check("stall_req_valid", {31'b0, imem_req_valid}, 32'd1);
      check("stall_req_addr", imem_req_addr, a);
      tick();
    end
    check("req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("req_addr", imem_req_addr, a);
    check("req_inst_valid", {31'b0, inst_valid}, 32'd0);
    imem_req_ready = 1'b1;
    tick();
    check("wait_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("wait_inst_valid", {31'b0, inst_valid}, 32'd0);
    check("wait_inst_kept", inst, prev_inst);
    check("wait_pc", pc, a);
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    tick();
    imem_rsp_data  = 32'hBAD1_BAD1;
    for (int i = 0; i < hold_stall; i++) begin
      check("stall_inst_valid", {31'b0, inst_valid}, 32'd1);
      check("stall_inst", inst, data);
      check("stall_pc", pc, a);
      tick();
    end
    check("hold_inst_valid", {31'b0, inst_valid}, 32'd1);
    check("hold_inst", inst, data);
    check("hold_pc", pc, a);
    check("hold_req_valid", {31'b0, imem_req_valid}, 32'd0);
    id_ready       = 1'b1;
    jump_flag      = jf;
    jump_pc        = jpc;
    tick();
    id_ready       = 1'b0;
    jump_flag      = 1'b0;
    jump_pc        = 32'h0;
    imem_rsp_valid = 1'b0;
    prev_inst      = data;
    check("post_inst_valid", {31'b0, inst_valid}, 32'd0);
  endtask

  // Main sequence
  initial begin
    n_checks       = 0;
    n_errors       = 0;
    prev_inst      = 32'h0;
    rst            = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    id_ready       = 1'b0;
    jump_flag      = 1'b0;
    jump_pc        = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("rst_pc", pc, 32'h8000_0000);
    check("rst_inst", inst, 32'h0);
    check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    check("rst_misalign", {31'b0, fetch_misalign}, 32'd0);
    rst = 1'b0;
    check("idle_req_valid", {31'b0, imem_req_valid}, 32'd0);
    tick();

    // Sequential fetches, redirect, stalls, wrap at the top of memory
    exp_q.push_back(32'h8000_0000);
    fetch(32'h0010_0093, 1'b0, 32'h0, 0, 0);
    exp_q.push_back(32'h8000_0004);
    fetch(32'h0020_0113, 1'b0, 32'h0, 0, 0);
    exp_q.push_back(32'h8000_0008);
    fetch(32'h0030_0193, 1'b1, 32'h8000_0100, 0, 0);
    exp_q.push_back(32'h8000_0100);
    fetch(32'h0040_0213, 1'b0, 32'h0, 5, 4);
    exp_q.push_back(32'h8000_0104);
    fetch(32'h0050_0293, 1'b1, 32'hFFFF_FFFC, 0, 0);
    exp_q.push_back(32'hFFFF_FFFC);
    fetch(32'h0060_0313, 1'b0, 32'h0, 0, 0);

    // Wrapped request, then asynchronous reset while waiting for the response
    check("wrap_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("wrap_req_addr", imem_req_addr, 32'h0);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    check("wrap_wait_req_valid", {31'b0, imem_req_valid}, 32'd0);
    rst = 1'b1;
    #1;
    check("arst_pc", pc, 32'h8000_0000);
    check("arst_inst", inst, 32'h0);
    check("arst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("arst_inst_valid", {31'b0, inst_valid}, 32'd0);
    tick();
    rst            = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h1234_5678;
    tick();
    imem_rsp_valid = 1'b0;
    check("reissue_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("reissue_req_addr", imem_req_addr, 32'h8000_0000);
    check("stray_inst", inst, 32'h0);
    check("stray_inst_valid", {31'b0, inst_valid}, 32'd0);
    prev_inst = 32'h0;

    // Redirect to a misaligned target
    exp_q.push_back(32'h8000_0000);
    fetch(32'h0070_0393, 1'b1, 32'h8000_0102, 0, 0);
`ifdef YSYX_22040237_IFU_MISALIGN_CHK_EN
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b1;
    id_ready       = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("err_misalign", {31'b0, fetch_misalign}, 32'd1);
      check("err_req_valid", {31'b0, imem_req_valid}, 32'd0);
      check("err_inst_valid", {31'b0, inst_valid}, 32'd0);
      check("err_pc", pc, 32'h8000_0102);
      tick();
    end
    rst = 1'b1;
    #1;
    check("err_rst_misalign", {31'b0, fetch_misalign}, 32'd0);
    check("err_rst_pc", pc, 32'h8000_0000);
    tick();
    rst = 1'b0;
`else
    check("misal_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("misal_req_addr", imem_req_addr, 32'h8000_0102);
    check("misal_flag", {31'b0, fetch_misalign}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
